// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
// The optional signed-overflow output is enabled by defining ALU_SEQ_OVF_EN.
package alu_seq_pkg;

   // Sequencer states. The encoding is exported on dbg_state.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } alu_seq_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Width of one ALU slice pass.
   localparam int NIB_W = 4;

   // Width of the pass counter. A single-pass configuration still needs one bit.
   function automatic int cnt_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/alu_seq_slice.sv
// Combinational 4-bit ALU slice: sum and carry-out of a + b + cin.
// Subtraction is handled upstream by inverting b and forcing cin high.
module alu_seq_slice
   import alu_seq_pkg::*;
(
   input  logic [NIB_W-1:0] i_a,
   input  logic [NIB_W-1:0] i_b,
   input  logic             i_cin,
   output logic [NIB_W-1:0] o_sum,
   output logic             o_cout
);

   logic [NIB_W:0] w_full;

   // Ripple add one nibble with a zero-extended carry-in.
   always_comb begin
      w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIB_W{1'b0}}, i_cin};
      o_sum  = w_full[NIB_W-1:0];
      o_cout = w_full[NIB_W];
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle add/sub sequencer driving a single 4-bit ALU slice.
// A WIDTH-bit request is taken over valid/ready, processed in WIDTH/4 passes
// LSB nibble first with the carry registered between passes, and returned on
// a valid/ready response channel.
// Defining ALU_SEQ_OVF_EN adds the registered signed-overflow output rsp_ovf.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE; rsp_valid is high only in DONE,
// and the response fields stay stable until the transfer edge.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output alu_seq_state_e   dbg_state
`ifdef ALU_SEQ_OVF_EN
   ,
   output logic             rsp_ovf
`endif
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = cnt_width(NIB);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

   // Reject widths that do not split into whole nibbles.
   if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("alu_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   alu_seq_state_e r_state;
   alu_seq_state_e w_next_state;

   // Operands are kept nibble-addressable so the pass counter selects a slice.
   logic [NIB-1:0][NIB_W-1:0] r_a;
   logic [NIB-1:0][NIB_W-1:0] r_b;
   logic [NIB-1:0][NIB_W-1:0] r_result;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_carry;
   logic                      r_cout;
`ifdef ALU_SEQ_OVF_EN
   logic                      r_ovf;
`endif

   logic [NIB_W-1:0] w_a_nib;
   logic [NIB_W-1:0] w_b_nib;
   logic [NIB_W-1:0] w_sum;
   logic             w_cout;
   logic             w_last;

   // Nibble mux feeding the slice for the current pass.
   always_comb begin
      w_a_nib = r_a[r_cnt];
      w_b_nib = r_b[r_cnt];
      w_last  = (r_cnt == LAST_CNT);
   end

   alu_seq_slice u_slice (
      .i_a    (w_a_nib),
      .i_b    (w_b_nib),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic: accept, run NIB passes, hold until consumed.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (req_valid)  w_next_state = S_RUN;
         S_RUN:   if (w_last)     w_next_state = S_DONE;
         S_DONE:  if (rsp_ready)  w_next_state = S_IDLE;
         default:                 w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs: handshake flags depend only on the state.
   always_comb begin
      req_ready = (r_state == S_IDLE);
      rsp_valid = (r_state == S_DONE);
      dbg_state = r_state;
   end

   // Datapath: latch operands on accept, then one nibble per RUN edge.
   // For subtraction B is stored inverted and the initial carry is 1, so the
   // slice always adds; the op bit itself is not needed after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_a     <= req_a;
                  r_b     <= req_b ^ {WIDTH{req_op}};
                  r_carry <= req_op;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_result[r_cnt] <= w_sum;
               r_carry         <= w_cout;
               if (w_last) begin
                  r_cout <= w_cout;
`ifdef ALU_SEQ_OVF_EN
                  // Same-sign operands producing a different-sign result.
                  r_ovf  <= (w_a_nib[NIB_W-1] == w_b_nib[NIB_W-1]) &&
                            (w_sum[NIB_W-1] != w_a_nib[NIB_W-1]);
`endif
                  r_cnt  <= '0;
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Response fields come straight from the registers.
   always_comb begin
      rsp_result = r_result;
      rsp_cout   = r_cout;
`ifdef ALU_SEQ_OVF_EN
      rsp_ovf    = r_ovf;
`endif
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (WIDTH=16): directed cases, backpressure, mid-run
// reset and randomized operations checked against an arithmetic model.
// Overflow checks are compiled in when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   localparam int W = 16;
   localparam int LAT = W / 4;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_op;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_result;
   logic          rsp_cout;
   alu_seq_state_e dbg_state;
`ifdef ALU_SEQ_OVF_EN
   logic          rsp_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .dbg_state  (dbg_state)
`ifdef ALU_SEQ_OVF_EN
      ,
      .rsp_ovf    (rsp_ovf)
`endif
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain modular arithmetic on whole words.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        output logic [W-1:0] res, output logic cout, output logic ovf);
      logic [W:0] full;
      if (op == OP_ADD) begin
         full = {1'b0, a} + {1'b0, b};
         res  = full[W-1:0];
         cout = full[W];
         ovf  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end else begin
         res  = a - b;
         cout = (a >= b);
         ovf  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
   endtask

   // Driver: one full transaction with bp cycles of response backpressure.
   // Called just after a rising edge with the DUT idle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input int bp, input string tag);
      logic [W-1:0] er;
      logic         ec;
      logic         eo;
      int           edges;
      model(a, b, op, er, ec, eo);
      check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      rsp_ready = (bp == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 0;
      while (!rsp_valid && edges < 20) begin
         check({tag, "_req_ready_run"}, 32'(req_ready), 32'd0);
         req_valid = 1'($urandom_range(0, 1));
         req_a     = W'($urandom);
         req_b     = W'($urandom);
         req_op    = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         edges++;
      end
      req_valid = 1'b0;
      check({tag, "_latency"}, 32'(edges), 32'(LAT));
      if (!rsp_valid) return;
      check({tag, "_result"}, 32'(rsp_result), 32'(er));
      check({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
`ifdef ALU_SEQ_OVF_EN
      check({tag, "_ovf"}, 32'(rsp_ovf), 32'(eo));
`endif
      for (int i = 0; i < bp; i++) begin
         if (i == 1) req_valid = 1'b1;
         @(posedge clk); #1;
         req_valid = 1'b0;
         check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hold_result"}, 32'(rsp_result), 32'(er));
         check({tag, "_hold_cout"}, 32'(rsp_cout), 32'(ec));
         check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
      check({tag, "_req_ready_after"}, 32'(req_ready), 32'd1);
      rsp_ready = 1'b0;
   endtask

   // Directed and random sequence
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_a = '0;
      req_b = '0;
      req_op = 1'b0;
      rsp_ready = 1'b0;
      #12;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_result", 32'(rsp_result), 32'd0);
      check("reset_cout", 32'(rsp_cout), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(S_IDLE));
`ifdef ALU_SEQ_OVF_EN
      check("reset_ovf", 32'(rsp_ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h1234, 16'h0FF1, OP_ADD, 0, "t1_add");
      do_op(16'hFFFF, 16'h0001, OP_ADD, 0, "t2_wrap");
      do_op(16'h0005, 16'h0007, OP_SUB, 1, "t3_sub_borrow");
      do_op(16'h0007, 16'h0005, OP_SUB, 0, "t3_sub_noborrow");
      do_op(16'h7FFF, 16'h0001, OP_ADD, 0, "t4_add_ovf");
      do_op(16'h8000, 16'h0001, OP_SUB, 0, "t4_sub_ovf");
      do_op(16'h0001, 16'h0001, OP_ADD, 0, "t4_add_noovf");

      // Backpressure with a pulsed request that must be dropped.
      do_op(16'hABCD, 16'h1111, OP_ADD, 5, "t5_bp");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("t5_no_extra_op", 32'(req_ready), 32'd1);
      end

      // Reset after two RUN passes.
      req_valid = 1'b1;
      req_a = 16'h5678;
      req_b = 16'h1111;
      req_op = OP_ADD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_req_ready", 32'(req_ready), 32'd1);
      check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_rst_result", 32'(rsp_result), 32'd0);
      check("t6_rst_cout", 32'(rsp_cout), 32'd0);
`ifdef ALU_SEQ_OVF_EN
      check("t6_rst_ovf", 32'(rsp_ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(16'h00FF, 16'h0001, OP_ADD, 0, "t6_after_rst");

      // Randomized operations with corner-biased operands.
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (n % 6 == 0) ra = 16'hFFFF;
         if (n % 6 == 1) rb = 16'h8000;
         if (n % 6 == 2) rb = ra;
         do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
